reg16_arbiter: RTL and testbench
================================

Name: reg16_arbiter

Overview:
- Arbitrates a shared 16-bit storage register between NUM_REQ requesters using a four-phase req/ack handshake and round-robin priority.
- Owns the register's load strobe. Read and write accesses are serialized, so exactly one requester reaches the register per transaction.
- Sits between CPU-side or peripheral masters and the Register16-style storage in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RST_VAL, 16'h0000, storage value after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request; level, held until ack is seen.
- we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read); sampled at grant.
- wdata  in  16*NUM_REQ  per-requester write data; slice i is [16*i+15:16*i]; sampled at grant.
- grant  out  NUM_REQ  one-hot; the current owner, held through the transaction.
- ack  out  NUM_REQ  one-hot; asserted to the owner when its access is complete.
- rdata  out  16  storage value captured for the owner; valid while ack is high.
- reg_q  out  16  live storage contents, for datapath observation.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, grant=0, ack=0, rdata=0, reg_q=RST_VAL, busy=0, rr pointer=NUM_REQ-1, so requester 0 has first priority. Reset applies immediately, with no clock needed.
- FSM states are IDLE, ACCESS, DONE and RELEASE.
- IDLE:
  - If req!=0, pick the first asserted requester searching from (ptr+1) mod NUM_REQ upward with wrap-around.
  - On that edge: grant=onehot(winner), latch we/wdata of the winner, go to ACCESS.
- ACCESS (1 cycle):
  - Write: storage loads the latched wdata on this edge.
  - Read: rdata takes reg_q.
  - Go to DONE.
- DONE:
  - ack[winner]=1.
  - For a write, rdata equals the newly written value (write-then-readback).
  - Stay until req[winner]==0, then ack drops on the next edge and the state goes to RELEASE.
- RELEASE (1 cycle): grant=0, ptr=winner, go to IDLE. This enforces a minimum one-cycle gap between transactions.
- Latency: req rises before edge 0 → grant after edge 0 → storage updated at edge 1 → ack visible after edge 1. If req drops immediately, the arbiter is back in IDLE 2 cycles later.
- Storage changes only in ACCESS with a latched write. reg_q is stable in all other states.
- Requests that arrive while busy are ignored until IDLE; they are not lost as long as req is held.
- If the owner drops req before ack (protocol violation), the access still completes. DONE exits on the first cycle where req is low.
- wdata/we changes after grant have no effect on the current transaction.
- Simultaneous requests in IDLE are resolved purely by the rr order. The winner becomes lowest priority next time, giving fairness within NUM_REQ transactions.
- Reset asserted mid-transaction: all outputs drop to reset values immediately. An in-flight write not yet clocked in ACCESS is discarded.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2, RELEASE=2'd3), data width constant 16, and the default RST_VAL.
- Sub-module rr_pick: combinational round-robin selector. Inputs are the req vector and ptr; outputs are the one-hot winner and its index. It is unit-testable alone.
- Storage is a resettable 16-bit register inside the block, with the load strobe driven by the FSM.

Test Plan:
- Reset and read: after reset, req=4'b0001, we=0 → grant=0001 after 1 edge, ack[0]=1 after 2 edges, rdata=16'h0000; drop req → busy=0 within 2 edges.
- Write then read: req0 writes 16'hBEEF → ack with rdata=BEEF, reg_q=BEEF; then req2 reads → rdata=BEEF.
- Fairness: req=4'b1111 held, releasing each after its ack → grant order 0,1,2,3,0; the rr pointer wraps from 3 to 0.
- Late requester: req1 rises while req0 is in DONE → grant[1] only after RELEASE; reg_q unchanged in between.
- Data stability: owner changes wdata from 16'h1234 to 16'hFFFF after grant → storage=1234.
- Async reset mid-transaction: rst_n low during ACCESS of a write of 16'hAAAA → grant, ack and busy fall immediately, reg_q=0000; the next transaction starts with requester 0 priority.

Source files
------------

// File: rtl/reg16_arbiter_pkg.sv
// Shared definitions for the 16-bit register arbiter: FSM encoding,
// data width and the default storage reset value.
package reg16_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] DEFAULT_RST_VAL = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/reg16_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted request
// strictly after ptr, wrapping around, wins.
module reg16_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        c   = 0;
        // k=NUM_REQ revisits ptr itself, so the last winner is served last
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!vld && req[c]) begin
                vld    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/reg16_arbiter.sv
// Round-robin req/ack arbiter owning the load strobe of a shared 16-bit
// storage register; one requester reaches the register per transaction.
module reg16_arbiter
    import reg16_arbiter_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter logic [DATA_W-1:0] RST_VAL = DEFAULT_RST_VAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [DATA_W*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [DATA_W-1:0]         reg_q,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdat_q, wdat_d, rdata_q, rdata_d, reg_d;
    logic               load;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    reg16_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    we_d    = we[pick_idx];
                    wdat_d  = wdata[DATA_W*int'(pick_idx) +: DATA_W];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                load    = we_q;
                // a write reads back the value being stored this edge
                rdata_d = we_q ? wdat_q : reg_q;
                ack_d   = grant_q;
                state_d = DONE;
            end
            DONE: begin
                if (!req[owner_q]) begin
                    ack_d   = '0;
                    grant_d = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        reg_d = load ? wdat_q : reg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdata_q <= '0;
            reg_q   <= RST_VAL;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            reg_q   <= reg_d;
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_reg16_arbiter.sv
// Directed and randomized checks of reg16_arbiter against a transaction-level
// model (storage word + round-robin pointer).
module tb_reg16_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  we = '0;
    logic [16*N-1:0] wdata = '0;
    logic [N-1:0]  grant, ack;
    logic [15:0]   rdata, reg_q;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int m_ptr = N - 1;
    logic [15:0] m_reg = 16'h0000;

    reg16_arbiter #(.NUM_REQ(N), .RST_VAL(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wdata(wdata),
        .grant(grant), .ack(ack), .rdata(rdata), .reg_q(reg_q), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Full transaction: owner drops req right after ack; optionally re-raises it.
    task automatic run_txn(input string tag, input logic [N-1:0] r, input logic [N-1:0] w,
                           input logic [16*N-1:0] d, input bit keep);
        int win;
        int n;
        logic [N-1:0] exp_g;
        req = r; we = w; wdata = d;
        win = model_winner(r);
        exp_g = '0;
        exp_g[win] = 1'b1;
        n = 0;
        while (grant == '0 && n < 20) begin step(); n++; end
        chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
        step();
        chk({tag, "_ack"}, 32'(ack), 32'(exp_g));
        if (w[win]) m_reg = d[16*win +: 16];
        chk({tag, "_rdata"}, 32'(rdata), 32'(m_reg));
        chk({tag, "_reg_q"}, 32'(reg_q), 32'(m_reg));
        req[win] = 1'b0;
        step();
        step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        m_ptr = win;
        if (keep) req[win] = 1'b1;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_reg_q", 32'(reg_q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // exact latency of a read by requester 0
        req = 4'b0001; we = '0;
        step();
        chk("lat_grant", 32'(grant), 32'h1);
        chk("lat_busy", 32'(busy), 32'h1);
        chk("lat_noack", 32'(ack), 32'h0);
        step();
        chk("lat_ack", 32'(ack), 32'h1);
        chk("lat_rdata", 32'(rdata), 32'h0);
        req = '0;
        step();
        chk("lat_ackdrop", 32'(ack), 32'h0);
        step();
        chk("lat_idle", 32'(busy), 32'h0);
        m_ptr = 0;

        // write BEEF then read it back from requester 2
        run_txn("wr_beef", 4'b0001, 4'b0001, {48'h0, 16'hBEEF}, 1'b0);
        run_txn("rd_beef", 4'b0100, 4'b0000, '0, 1'b0);

        // fairness from fresh reset: all held, expect 0,1,2,3,0
        rst_n = 1'b0; #1; rst_n = 1'b1;
        m_ptr = N - 1; m_reg = 16'h0000;
        req = 4'b1111;
        run_txn("fair0", 4'b1111, '0, '0, 1'b1);
        run_txn("fair1", req, '0, '0, 1'b1);
        run_txn("fair2", req, '0, '0, 1'b1);
        run_txn("fair3", req, '0, '0, 1'b1);
        run_txn("fair4", req, '0, '0, 1'b0);
        chk("fair_wrap_ptr", 32'(m_ptr), 32'd0);
        req = '0;
        step();

        // late requester: req1 during req0's DONE waits for RELEASE
        req = 4'b0001; we = 4'b0001; wdata = {48'h0, 16'h5A5A};
        step(); step();
        chk("late_ack0", 32'(ack), 32'h1);
        m_reg = 16'h5A5A;
        req = 4'b0011;
        step(); step();
        chk("late_hold", 32'(grant), 32'h1);
        req = 4'b0010;
        step();
        chk("late_rel", 32'(grant), 32'h0);
        step();
        chk("late_gap", 32'(grant), 32'h0);
        chk("late_regq", 32'(reg_q), 32'h5A5A);
        step();
        chk("late_grant1", 32'(grant), 32'h2);
        step();
        chk("late_ack1", 32'(ack), 32'h2);
        req = '0;
        step(); step();
        m_ptr = 1;

        // data stability: wdata changes after grant are ignored
        req = 4'b0100; we = 4'b0100; wdata = {16'h0, 16'h1234, 32'h0};
        step();
        chk("stab_grant", 32'(grant), 32'h4);
        wdata = {16'h0, 16'hFFFF, 32'h0}; we = '0;
        step();
        chk("stab_reg_q", 32'(reg_q), 32'h1234);
        chk("stab_rdata", 32'(rdata), 32'h1234);
        m_reg = 16'h1234;
        req = '0;
        step(); step();
        m_ptr = 2;

        // async reset during ACCESS of an AAAA write
        req = 4'b0001; we = 4'b0001; wdata = {48'h0, 16'hAAAA};
        step();
        chk("ar_grant", 32'(grant), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant0", 32'(grant), 32'h0);
        chk("ar_ack0", 32'(ack), 32'h0);
        chk("ar_busy0", 32'(busy), 32'h0);
        chk("ar_reg_q", 32'(reg_q), 32'h0);
        req = '0; we = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = N - 1; m_reg = 16'h0000;
        run_txn("ar_next", 4'b1111, '0, '0, 1'b0);
        req = '0;
        step();

        // randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(1, (1 << N) - 1));
            run_txn($sformatf("rnd%0d", t), r, N'($urandom),
                    {$urandom, $urandom}, 1'b0);
            req = '0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
